video_pixel_fifo: RTL and testbench

Parametrised successor of the single-word video buffer. It is a multi-word ring FIFO between the frame/pixel fetch logic and the VGA timing generator. Packed words enter with a valid/ready handshake. They are unpacked into one pixel per enabled clock, LSB slice first, and the block reports fill level, empty, full, a low-watermark refill request and a sticky underrun flag.

---
 rtl/video_pkg.sv | 17 +
 rtl/video_fifo_mem.sv | 24 ++
 rtl/video_pixel_fifo.sv | 131 +++++++++++++
 tb/tb_video_pixel_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video pixel FIFO: default geometry, pixel type
// and the word-to-pixel slice select.
package video_pkg;

  localparam int PIXEL_W_DEF     = 8;
  localparam int WORD_PIXELS_DEF = 4;
  localparam int IDX_W_DEF       = (WORD_PIXELS_DEF > 1) ? $clog2(WORD_PIXELS_DEF) : 1;

  typedef logic [PIXEL_W_DEF-1:0]                 pixel_t;
  typedef logic [WORD_PIXELS_DEF*PIXEL_W_DEF-1:0] word_t;

  // Pixel idx of a packed word; pixel 0 sits in the least significant slice.
  function automatic pixel_t slice(input word_t word, input logic [IDX_W_DEF-1:0] idx);
    return word[idx*PIXEL_W_DEF +: PIXEL_W_DEF];
  endfunction

endpackage

// File: rtl/video_fifo_mem.sv
// Word storage for the pixel FIFO: synchronous write, asynchronous read.
// No reset; contents are meaningless until written.
module video_fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/video_pixel_fifo.sv
// Ring FIFO of packed pixel words feeding the VGA timing generator; words are
// unpacked LSB slice first, one pixel per enabled clock.
module video_pixel_fifo
  import video_pkg::*;
#(
  parameter int PIXEL_W     = PIXEL_W_DEF,
  parameter int WORD_PIXELS = WORD_PIXELS_DEF,
  parameter int DEPTH_WORDS = 4,
  parameter int WATERMARK   = 2,
  parameter int PTR_W       = $clog2(DEPTH_WORDS),
  parameter int LVL_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic                         clk25MHz,
  input  logic                         reset,
  input  logic [WORD_PIXELS*PIXEL_W-1:0] wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic                         en,
  output logic [PIXEL_W-1:0]           video,
  output logic                         video_valid,
  output logic [LVL_W-1:0]             level,
  output logic                         empty,
  output logic                         full,
  output logic                         watermark_on,
  output logic                         underrun,
  input  logic                         underrun_clr
);

  localparam int IDX_W = (WORD_PIXELS > 1) ? $clog2(WORD_PIXELS) : 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PIXEL_W-1:0] video_q, video_d;
  logic               video_valid_q, video_valid_d;
  logic               underrun_q, underrun_d;

  logic [WORD_PIXELS*PIXEL_W-1:0] rd_word;
  logic [PIXEL_W-1:0]             head_pix;
  logic                           wr_fire, pop, pop_last;

  // Status is decoded from the registered level only, so it never glitches
  // and a write cannot use a slot freed by a pop in the same cycle.
  assign empty        = (level_q == '0);
  assign full         = (level_q == LVL_W'(DEPTH_WORDS));
  assign watermark_on = (level_q <= LVL_W'(WATERMARK));
  assign wr_ready     = !full;

  assign wr_fire  = wr_valid && wr_ready;
  assign pop      = en && !empty;
  assign pop_last = pop && (pix_idx_q == IDX_W'(WORD_PIXELS - 1));

  video_fifo_mem #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (WORD_PIXELS*PIXEL_W),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk  (clk25MHz),
    .we   (wr_fire),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(rd_word)
  );

  if (PIXEL_W == PIXEL_W_DEF && WORD_PIXELS == WORD_PIXELS_DEF) begin : g_pkg_slice
    assign head_pix = slice(rd_word, pix_idx_q);
  end else begin : g_gen_slice
    assign head_pix = rd_word[pix_idx_q*PIXEL_W +: PIXEL_W];
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pix_idx_d     = pix_idx_q;
    level_d       = level_q;
    video_d       = video_q;
    video_valid_d = 1'b0;
    underrun_d    = underrun_q && !underrun_clr;

    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (pop) begin
      video_d       = head_pix;
      video_valid_d = 1'b1;
      if (pop_last) begin
        pix_idx_d = '0;
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      end else begin
        pix_idx_d = pix_idx_q + IDX_W'(1);
      end
    end else if (en) begin
      // Starved display request: blank the pixel and latch the error.
      video_d    = '0;
      underrun_d = 1'b1;
    end

    case ({wr_fire, pop_last})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pix_idx_q     <= '0;
      level_q       <= '0;
      video_q       <= '0;
      video_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pix_idx_q     <= pix_idx_d;
      level_q       <= level_d;
      video_q       <= video_d;
      video_valid_q <= video_valid_d;
      underrun_q    <= underrun_d;
    end
  end

  assign level       = level_q;
  assign video       = video_q;
  assign video_valid = video_valid_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_video_pixel_fifo.sv
// Self-checking bench for video_pixel_fifo: directed scenarios with literal
// expectations plus randomized traffic against a word-queue model.
module tb_video_pixel_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        en;
  logic [7:0]  video;
  logic        video_valid;
  logic [2:0]  level;
  logic        empty, full, watermark_on;
  logic        underrun;
  logic        underrun_clr;

  int checks = 0;
  int errors = 0;

  video_pixel_fifo dut (
    .clk25MHz    (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .en          (en),
    .video       (video),
    .video_valid (video_valid),
    .level       (level),
    .empty       (empty),
    .full        (full),
    .watermark_on(watermark_on),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
  );

  always #20 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of whole words plus the count of pixels already
  // taken from the head word.
  logic [31:0] mq[$];
  int          mcnt   = 0;
  logic [7:0]  mvideo = 8'h00;
  logic        mvalid = 1'b0;
  logic        mund   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mcnt   = 0;
      mvideo = 8'h00;
      mvalid = 1'b0;
      mund   = 1'b0;
    end else begin
      bit          can_wr;
      bit          was_empty;
      logic [31:0] head;
      can_wr    = (mq.size() < DEPTH);
      was_empty = (mq.size() == 0);
      if (en && !was_empty) begin
        head   = mq[0];
        mvideo = head[8*mcnt +: 8];
        mvalid = 1'b1;
        mcnt++;
        if (mcnt == 4) begin
          void'(mq.pop_front());
          mcnt = 0;
        end
      end else if (en) begin
        mvideo = 8'h00;
        mvalid = 1'b0;
      end else begin
        mvalid = 1'b0;
      end
      if (en && was_empty) mund = 1'b1;
      else if (underrun_clr) mund = 1'b0;
      if (wr_valid && can_wr) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp_video",       {24'h0, video},      {24'h0, mvideo});
      chk("cmp_video_valid", {31'h0, video_valid}, {31'h0, mvalid});
      chk("cmp_level",       {29'h0, level},      mq.size());
      chk("cmp_empty",       {31'h0, empty},      {31'h0, mq.size() == 0});
      chk("cmp_full",        {31'h0, full},       {31'h0, mq.size() == DEPTH});
      chk("cmp_watermark",   {31'h0, watermark_on}, {31'h0, mq.size() <= 2});
      chk("cmp_wr_ready",    {31'h0, wr_ready},   {31'h0, mq.size() < DEPTH});
      chk("cmp_underrun",    {31'h0, underrun},   {31'h0, mund});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_pix [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    reset = 1'b0; wr_valid = 1'b0; wr_data = '0; en = 1'b0; underrun_clr = 1'b0;
    #1 reset = 1'b1;
    #50;
    @(posedge clk); #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_empty",    {31'h0, empty}, 1);
    chk("rst_full",     {31'h0, full}, 0);
    chk("rst_wm",       {31'h0, watermark_on}, 1);
    chk("rst_wr_ready", {31'h0, wr_ready}, 1);
    chk("rst_level",    {29'h0, level}, 0);
    chk("rst_video",    {24'h0, video}, 0);
    chk("rst_underrun", {31'h0, underrun}, 0);
    chk("rst_vvalid",   {31'h0, video_valid}, 0);

    // Single word, LSB pixel first
    wr_data = 32'h44332211; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("single_level_in", {29'h0, level}, 1);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("single_pix", {24'h0, video}, {24'h0, exp_pix[k]});
      chk("single_vvalid", {31'h0, video_valid}, 1);
      if (k < 3) chk("single_level_mid", {29'h0, level}, 1);
    end
    en = 1'b0;
    chk("single_level_out", {29'h0, level}, 0);
    chk("single_empty", {31'h0, empty}, 1);

    // Fill and backpressure
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hA0B0C000 + i; wr_valid = 1'b1;
      tick();
    end
    chk("fill_ready", {31'h0, wr_ready}, 0);
    chk("fill_full",  {31'h0, full}, 1);
    chk("fill_level", {29'h0, level}, 4);
    chk("fill_wm",    {31'h0, watermark_on}, 0);
    wr_data = 32'hCAFE0005;
    tick(); tick();
    chk("fill_held_level", {29'h0, level}, 4);
    en = 1'b1;
    repeat (4) tick();
    en = 1'b0;
    chk("fill_pop_level", {29'h0, level}, 3);
    chk("fill_ready_back", {31'h0, wr_ready}, 1);
    tick();
    wr_valid = 1'b0;
    chk("fill_fifth_in", {29'h0, level}, 4);
    en = 1'b1;
    repeat (16) tick();
    en = 1'b0;
    chk("fill_drained", {31'h0, empty}, 1);

    // Simultaneous write and final pop at level 2, across pointer wrap
    for (int i = 0; i < 2; i++) begin
      wr_data = $urandom; wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    chk("wrap_level_start", {29'h0, level}, 2);
    for (int w = 2; w < 8; w++) begin
      en = 1'b1;
      repeat (3) tick();
      wr_data = $urandom; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      chk("wrap_level_hold", {29'h0, level}, 2);
    end
    repeat (8) tick();
    en = 1'b0;
    chk("wrap_drained", {31'h0, empty}, 1);

    // Underrun and its clear priority
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("udr_video",  {24'h0, video}, 0);
    chk("udr_vvalid", {31'h0, video_valid}, 0);
    chk("udr_set",    {31'h0, underrun}, 1);
    repeat (3) tick();
    chk("udr_sticky", {31'h0, underrun}, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("udr_clear", {31'h0, underrun}, 0);
    underrun_clr = 1'b1; en = 1'b1;
    tick();
    underrun_clr = 1'b0; en = 1'b0;
    chk("udr_set_wins", {31'h0, underrun}, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("udr_clear2", {31'h0, underrun}, 0);

    // Asynchronous reset mid-word
    wr_data = 32'hDDCCBBAA; wr_valid = 1'b1;
    tick();
    wr_data = 32'h99887766;
    tick();
    wr_valid = 1'b0;
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    chk("mid_second_pix", {24'h0, video}, 32'hBB);
    #5 reset = 1'b1;
    #1;
    chk("mid_rst_level", {29'h0, level}, 0);
    chk("mid_rst_empty", {31'h0, empty}, 1);
    chk("mid_rst_video", {24'h0, video}, 0);
    #5 reset = 1'b0;
    tick();
    wr_data = 32'h04030201; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("mid_first_pix", {24'h0, video}, 32'h01);
    chk("mid_first_vvalid", {31'h0, video_valid}, 1);

    // Randomized traffic, write-heavy then read-heavy
    for (int c = 0; c < 600; c++) begin
      if (c < 300) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        en       = ($urandom_range(0, 3) == 0);
      end else begin
        wr_valid = ($urandom_range(0, 7) == 0);
        en       = ($urandom_range(0, 3) != 0);
      end
      wr_data      = $urandom;
      underrun_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    wr_valid = 1'b0; en = 1'b0; underrun_clr = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
